mash_ddsm_core: RTL

MASH_DDSM_CORE -- requirements
Module: mash_ddsm_core

---
 rtl/mash_ddsm_pkg.sv | 28 ++
 rtl/mash_ddsm_core_acc.sv | 42 ++++
 rtl/mash_ddsm_core.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mash_ddsm_pkg.sv
// Shared types and constants for the MASH 1-1-1 delta-sigma modulator.
package mash_ddsm_pkg;

  localparam int unsigned ACC_W       = 8;
  localparam int unsigned FILL_CYCLES = 3;

  // Modulator order encodings on i_sel_order.
  localparam logic [1:0] OrdFirst    = 2'd0;
  localparam logic [1:0] OrdSecond   = 2'd1;
  localparam logic [1:0] OrdThird    = 2'd2;
  localparam logic [1:0] OrdThirdAlt = 2'd3;

  // Dither LFSR: x^12 + x^6 + x^4 + x + 1, feedback taps on bits 11, 5, 3, 0.
  localparam logic [12:0] LFSR_POLY = 13'h1053;
  localparam logic [11:0] LFSR_TAPS = 12'h829;

  typedef enum logic [1:0] {StClear, StFill, StRun} mash_state_e;

  // Error-cancellation network: c1[n-2] + d(c2)[n-1] + d2(c3)[n].
  function automatic logic signed [3:0] mash_combine(input logic c1_n2, input logic c2_n1,
                                                     input logic c2_n2, input logic c3_n,
                                                     input logic c3_n1, input logic c3_n2);
    mash_combine = $signed({3'b000, c1_n2}) + $signed({3'b000, c2_n1})
                 - $signed({3'b000, c2_n2}) + $signed({3'b000, c3_n})
                 - $signed({2'b00, c3_n1, 1'b0}) + $signed({3'b000, c3_n2});
  endfunction

endpackage

// File: rtl/mash_ddsm_core_acc.sv
// One masked first-order accumulator with a one-hot carry tap on its 9-bit sum.
module mash_acc_stage
  import mash_ddsm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] load_val_i,
  input  logic [ACC_W-1:0] mask_i,
  input  logic [ACC_W:0]   in_i,
  input  logic [ACC_W:0]   cout_sel_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             carry_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + in_i;
    carry_o = en_i & (|(sum & cout_sel_i));
    if (!en_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = load_val_i & mask_i;
    end else begin
      acc_d = sum[ACC_W-1:0] & mask_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mash_ddsm_core.sv
// MASH 1-1-1 delta-sigma modulator core with clear/fill/run sequencing and phase nudge.
// Optional dither LFSR on the first-stage carry-in is enabled by defining MASH_DITHER_EN.
module mash_ddsm_core
  import mash_ddsm_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_frac_a,
  input  logic [7:0]  i_frac_b,
  input  logic        i_sel_frac,
  input  logic [11:0] i_seed,
  input  logic [1:0]  i_sel_order,
  input  logic [7:0]  i_sum_sel,
  input  logic [8:0]  i_cout_sel,
  input  logic        i_mashreseten,
  input  logic        i_phaseadjusten,
  output logic [3:0]  o_dsm,
  output logic        o_valid
);

  mash_state_e      state_q;
  logic [1:0]       fill_cnt_q;
  logic             valid_q;
  logic             ph_q;
  logic [1:0]       c1_dly_q, c2_dly_q, c3_dly_q;
  logic [3:0]       dsm_q;

  logic             load;
  logic             phase_pulse;
  logic             ci;
  logic             en2, en3;
  logic [ACC_W-1:0] frac_m;
  logic [ACC_W:0]   in1;
  logic [ACC_W-1:0] acc1, acc2, acc3;
  logic             c1, c2, c3;
  logic signed [3:0] y;

  // Reload happens on the edge that enters CLEAR and on every edge spent in CLEAR.
  assign load        = i_mashreseten | (state_q == StClear);
  assign phase_pulse = i_phaseadjusten & ~ph_q & (state_q != StClear);

`ifdef MASH_DITHER_EN
  logic [11:0] lfsr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q <= '0;
    end else if (load) begin
      lfsr_q <= (i_seed == 12'h000) ? 12'h001 : i_seed;
    end else begin
      lfsr_q <= {lfsr_q[10:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign ci = phase_pulse | lfsr_q[0];
`else
  assign ci = phase_pulse;
`endif

  assign en2    = (i_sel_order != OrdFirst);
  assign en3    = (i_sel_order == OrdThird) | (i_sel_order == OrdThirdAlt);
  assign frac_m = (i_sel_frac ? i_frac_b : i_frac_a) & i_sum_sel;
  assign in1    = {1'b0, frac_m} + {{ACC_W{1'b0}}, ci};

  mash_acc_stage u_stage1 (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .en_i       (1'b1),
    .load_i     (load),
    .load_val_i (i_seed[7:0]),
    .mask_i     (i_sum_sel),
    .in_i       (in1),
    .cout_sel_i (i_cout_sel),
    .acc_o      (acc1),
    .carry_o    (c1)
  );

  mash_acc_stage u_stage2 (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .en_i       (en2),
    .load_i     (load),
    .load_val_i ({4'b0000, i_seed[11:8]}),
    .mask_i     (i_sum_sel),
    .in_i       ({1'b0, acc1}),
    .cout_sel_i (i_cout_sel),
    .acc_o      (acc2),
    .carry_o    (c2)
  );

  mash_acc_stage u_stage3 (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .en_i       (en3),
    .load_i     (load),
    .load_val_i ('0),
    .mask_i     (i_sum_sel),
    .in_i       ({1'b0, acc2}),
    .cout_sel_i (i_cout_sel),
    .acc_o      (acc3),
    .carry_o    (c3)
  );

  assign y = mash_combine(c1_dly_q[1], c2_dly_q[0], c2_dly_q[1], c3, c3_dly_q[0], c3_dly_q[1]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StClear;
      fill_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else if (i_mashreseten) begin
      state_q    <= StClear;
      fill_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          state_q    <= StFill;
          fill_cnt_q <= '0;
          valid_q    <= 1'b0;
        end
        StFill: begin
          if (fill_cnt_q == 2'(FILL_CYCLES - 1)) begin
            state_q <= StRun;
            valid_q <= 1'b1;
          end else begin
            fill_cnt_q <= fill_cnt_q + 2'd1;
          end
        end
        StRun: begin
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= StClear;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ph_q     <= 1'b0;
      c1_dly_q <= '0;
      c2_dly_q <= '0;
      c3_dly_q <= '0;
      dsm_q    <= '0;
    end else begin
      ph_q <= i_phaseadjusten;
      if (load) begin
        c1_dly_q <= '0;
        c2_dly_q <= '0;
        c3_dly_q <= '0;
        dsm_q    <= '0;
      end else begin
        c1_dly_q <= {c1_dly_q[0], c1};
        c2_dly_q <= {c2_dly_q[0], c2};
        c3_dly_q <= {c3_dly_q[0], c3};
        dsm_q    <= y;
      end
    end
  end

  assign o_dsm   = dsm_q;
  assign o_valid = valid_q;

  // Third accumulator only feeds its carry; its value has no consumer.
  logic unused_acc3;
  assign unused_acc3 = ^acc3;

endmodule
